// File: rtl/op_sequencer.sv
// op_sequencer: FIFO of host opcodes, each run through a SETUP/FIRE/RUN/DONE handshake with the control FSM.
// Define SEQ_WDOG_EN to build a watchdog that aborts a command stuck in RUN for WDOG_LIMIT cycles.
`ifndef NTT
`define NTT 2'd0
`endif
`ifndef PWM0
`define PWM0 2'd1
`endif
`ifndef PWM1
`define PWM1 2'd2
`endif
`ifndef INTT
`define INTT 2'd3
`endif

module op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    output logic                     cmd_ready,
    output logic [1:0]               opcode,
    output logic                     start,
    input  logic                     finish,
    output logic                     busy,
    output logic                     op_done,
    output logic [1:0]               op_done_code,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          push, pop, expire, load;

    assign cmd_ready    = level != FULL;
    assign push         = cmd_valid && cmd_ready;
    assign pop          = state == DONE || expire;
    assign load         = state == IDLE && level != '0;
    assign start        = state == FIRE;
    assign busy         = state != IDLE;
    assign op_done      = state == DONE;
    assign op_done_code = (op_done || timeout) ? opcode : 2'd0;

`ifdef SEQ_WDOG_EN
    localparam int CW = $clog2(WDOG_LIMIT + 1);
    localparam logic [CW-1:0] WLAST = CW'(WDOG_LIMIT - 1);
    logic [CW-1:0] wdog_cnt;
    logic          timeout_q;
    // Counter sits at zero outside RUN, so it is already clear on RUN entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_cnt  <= (state == RUN) ? wdog_cnt + 1'b1 : '0;
            timeout_q <= expire;
        end
    end
    assign expire  = state == RUN && !finish && wdog_cnt == WLAST;
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load ? SETUP : IDLE;
            SETUP:   state_nx = FIRE;
            FIRE:    state_nx = RUN;
            RUN:     state_nx = finish ? DONE : (expire ? IDLE : RUN);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            opcode <= `NTT;
            level  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            state  <= state_nx;
            opcode <= load ? mem[rptr] : opcode;
            level  <= level + LW'(push) - LW'(pop);
            wptr   <= push ? wptr + 1'b1 : wptr;
            rptr   <= pop ? rptr + 1'b1 : rptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= cmd_op;
    end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: cycle-by-cycle vector table plus directed reset and watchdog sequences.
module tb_op_sequencer;
    logic       clk, rst, cmd_valid, finish;
    logic [1:0] cmd_op;
    logic       cmd_ready, start, busy, op_done, timeout;
    logic [1:0] opcode, op_done_code;
    logic [2:0] level;
    int         n_cmp = 0;
    int         n_err = 0;

    op_sequencer #(.DEPTH(4), .WDOG_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .opcode(opcode), .start(start), .finish(finish),
        .busy(busy), .op_done(op_done), .op_done_code(op_done_code),
        .timeout(timeout), .level(level)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic        fin;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    // exp packs {start, busy, op_done, op_done_code, opcode, level, cmd_ready}
    function automatic vec_t mk(int v, int op, int fin, int s, int b, int d, int c, int o, int l, int r);
        vec_t e;
        e.v   = 1'(v);
        e.op  = 2'(op);
        e.fin = 1'(fin);
        e.exp = {1'(s), 1'(b), 1'(d), 2'(c), 2'(o), 3'(l), 1'(r)};
        return e;
    endfunction

    function automatic logic [10:0] outs();
        return {start, busy, op_done, op_done_code, opcode, level, cmd_ready};
    endfunction

    task automatic chk(string name, logic [10:0] act, logic [10:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    initial begin
        int k;
        //             v op f  s b d c o l r
        tbl.push_back(mk(0,0,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1, 1,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,2,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,2,1,1));
        tbl.push_back(mk(0,0,0, 1,1,0,0,2,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,2,1,1));
        tbl.push_back(mk(0,0,1, 0,1,1,2,2,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,2,0,1));
        tbl.push_back(mk(1,1,0, 0,0,0,0,2,1,1));
        tbl.push_back(mk(1,2,0, 0,1,0,0,1,2,1));
        tbl.push_back(mk(1,3,0, 1,1,0,0,1,3,1));
        tbl.push_back(mk(1,0,0, 0,1,0,0,1,4,0));
        tbl.push_back(mk(1,1,0, 0,1,0,0,1,4,0));
        tbl.push_back(mk(1,1,1, 0,1,1,1,1,4,0));
        tbl.push_back(mk(1,1,0, 0,0,0,0,1,3,1));
        tbl.push_back(mk(1,1,0, 0,1,0,0,2,4,0));
        tbl.push_back(mk(0,0,0, 1,1,0,0,2,4,0));
        tbl.push_back(mk(0,0,0, 0,1,0,0,2,4,0));
        tbl.push_back(mk(0,0,1, 0,1,1,2,2,4,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,2,3,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,3,3,1));
        tbl.push_back(mk(0,0,0, 1,1,0,0,3,3,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,3,3,1));
        tbl.push_back(mk(0,0,1, 0,1,1,3,3,3,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,3,2,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,2,1));
        tbl.push_back(mk(0,0,0, 1,1,0,0,0,2,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,2,1));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0,2,1));
        tbl.push_back(mk(1,3,0, 0,0,0,0,0,2,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,1,2,1));
        tbl.push_back(mk(0,0,0, 1,1,0,0,1,2,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,1,2,1));
        tbl.push_back(mk(0,0,1, 0,1,1,1,1,2,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,1,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,3,1,1));
        tbl.push_back(mk(0,0,0, 1,1,0,0,3,1,1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,3,1,1));
        tbl.push_back(mk(0,0,1, 0,1,1,3,3,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,3,0,1));

        rst = 0; cmd_valid = 0; cmd_op = 0; finish = 0;
        #12;
        chk("in_reset", outs(), 11'b0_0_0_00_00_000_1);
        @(negedge clk);
        rst = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            cmd_valid = tbl[i].v; cmd_op = tbl[i].op; finish = tbl[i].fin;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), outs(), tbl[i].exp);
        end
        @(negedge clk);
        cmd_valid = 0; finish = 0;

        // Reset while a command is in RUN with three queued.
        for (int i = 1; i <= 3; i++) begin
            cmd_valid = 1; cmd_op = 2'(i);
            @(negedge clk);
        end
        cmd_valid = 0;
        @(posedge clk);
        #1;
        chk("pre_reset_run", outs(), 11'b0_1_0_00_01_011_1);
        #2 rst = 0;
        #1;
        chk("async_reset", outs(), 11'b0_0_0_00_00_000_1);
        @(negedge clk);
        @(negedge clk);
        chk("held_reset", outs(), 11'b0_0_0_00_00_000_1);
        rst = 1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            finish = i[0];
            @(posedge clk);
            #1;
            if (op_done || busy || level != 0) k++;
            @(negedge clk);
        end
        finish = 0;
        chk("quiet_after_reset", 11'(k), 11'd0);

`ifdef SEQ_WDOG_EN
        cmd_valid = 1; cmd_op = 2;
        @(negedge clk);
        cmd_op = 3;
        @(negedge clk);
        cmd_valid = 0;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (start) k = i;
        end
        chk("wdog_start_seen", 11'(k != 0), 11'd1);
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (timeout) k = i;
            else if (op_done) k = 100 + i;
        end
        chk("wdog_delay", 11'(k), 11'd17);
        chk("wdog_outputs", {timeout, op_done, op_done_code, level, busy}, 11'b1_0_10_001_0);
        @(posedge clk);
        #1;
        chk("wdog_pulse_width", {timeout, busy, opcode}, 11'b0_1_11);
        @(posedge clk);
        #1;
        chk("wdog_next_start", {start, opcode}, 11'b1_11);
        @(negedge clk);
        @(negedge clk);
        finish = 1;
        @(posedge clk);
        #1;
        chk("wdog_next_done", {op_done, op_done_code, timeout, level}, 11'b1_11_0_001);
        @(negedge clk);
        finish = 0;
`else
        cmd_valid = 1; cmd_op = 1;
        @(negedge clk);
        cmd_valid = 0;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (start) k = i;
        end
        chk("long_start_seen", 11'(k != 0), 11'd1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (timeout || !busy || op_done) k++;
        end
        chk("long_run_no_timeout", 11'(k), 11'd0);
        @(negedge clk);
        finish = 1;
        @(posedge clk);
        #1;
        chk("long_run_done", {op_done, op_done_code, timeout, level}, 11'b1_01_0_001);
        @(negedge clk);
        finish = 0;
`endif
        @(posedge clk);
        #1;
        chk("final_idle", outs(), {1'b0, 1'b0, 1'b0, 2'b00, opcode, 3'd0, 1'b1});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
